xadc_drp_responder: RTL and testbench
=====================================

XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 100, meaning clk cycles per conversion (legal 4..65535).
REQ-002 SHALL have parameter READ_LATENCY, default 4, meaning cycles from den_in to drdy_out (legal 1..15).
REQ-003 SHALL have parameter CHANNEL, default 5'h16, meaning the auxiliary channel address this block converts.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sample_in  input  12  digital value standing in for the analog input.
REQ-007 den_in  input  1  DRP enable, one-cycle request strobe.
REQ-008 dwe_in  input  1  DRP write enable, qualified by den_in.
REQ-009 daddr_in  input  7  DRP register address.
REQ-010 di_in  input  16  DRP write data.
REQ-011 drdy_out  output  1  one-cycle transaction-complete strobe.
REQ-012 do_out  output  16  DRP read data, valid only while drdy_out=1.
REQ-013 eoc_out  output  1  one-cycle end-of-conversion strobe.
REQ-014 channel_out  output  5  channel of the most recent conversion.
REQ-015 busy_out  output  1  high while a DRP transaction is pending.
REQ-016 proto_err_out  output  1  sticky protocol-violation flag.

Function
REQ-017 Conversion counter SHALL count 0..CONV_CYCLES-1 and wrap to 0.
REQ-018 On the edge where the counter wraps, the result register SHALL load {sample_in,4'b0000} and eoc_out SHALL be 1 for exactly that following cycle.
REQ-019 channel_out SHALL equal CHANNEL from the first eoc_out onward.
REQ-020 Register map: address CHANNEL = result (read-only); 7'h40, 7'h41, 7'h42 = config regs CFG0..CFG2; all other addresses SHALL read 16'h0000 and ignore writes.
REQ-021 den_in=1 while busy_out=0 SHALL be accepted: capture daddr_in, dwe_in and di_in; busy_out=1 from the next cycle.
REQ-022 Read data SHALL be the addressed register's value in the acceptance cycle, before any same-edge result update.
REQ-023 drdy_out SHALL pulse for one cycle exactly READ_LATENCY cycles after the acceptance cycle; busy_out SHALL drop in that same cycle.
REQ-024 A new den_in in the drdy_out cycle SHALL be accepted.
REQ-025 do_out SHALL be 16'h0000 whenever drdy_out=0, and on write completion.
REQ-026 Writes SHALL take effect on the drdy_out cycle, subject to REQ-033.
REQ-027 den_in=1 while busy_out=1 SHALL be ignored and SHALL set proto_err_out=1 until reset.
REQ-028 State machine: IDLE -> (den accepted) WAIT -> (latency count = READ_LATENCY-1) DONE -> IDLE, or DONE -> WAIT when a new den is accepted in DONE.
REQ-029 Conversion timing SHALL be independent of DRP activity.

Reset
REQ-030 While rst_n=0: drdy_out=0, do_out=0, eoc_out=0, busy_out=0, proto_err_out=0, channel_out=0, result=0, counter=0, state IDLE.
REQ-031 Reset values: CFG0=16'h0016, CFG1=16'h2000, CFG2=16'h0400.
REQ-032 Reset mid-transaction SHALL abort it with no drdy_out; first eoc_out SHALL come CONV_CYCLES cycles after rst_n rises.

Configuration
REQ-033 Macro XADC_DRP_WRITE_EN: when defined, writes to CFG0..CFG2 update them per REQ-026; when undefined, all writes are ignored and config regs hold reset values, while drdy_out timing is unchanged.

Verification
REQ-034 Reset release, sample_in=12'hABC, CONV_CYCLES=100 -> eoc_out pulses at cycles 100, 200, ...; read 7'h16 after the first pulse returns 16'hABC0.
REQ-035 den_in with daddr_in=7'h16, READ_LATENCY=4 -> drdy_out one cycle, exactly 4 cycles later; busy_out high for cycles 1..3 only.
REQ-036 Write 16'h1234 to 7'h41, then read it back -> 16'h1234 with XADC_DRP_WRITE_EN defined, 16'h2000 without it.
REQ-037 Second den_in 2 cycles after the first -> only one drdy_out; proto_err_out=1 and stays 1; back-to-back den_in in the drdy_out cycle -> two drdy_out, no error.
REQ-038 den_in on the eoc_out update edge for 7'h16 -> returns the old result; read 7'h7F -> 16'h0000.
REQ-039 rst_n low during WAIT -> no drdy_out, busy_out=0; the next read after release completes normally.

Source files
------------

// File: rtl/xadc_drp_responder.sv
// rtl/xadc_drp_responder.sv - XADC-style DRP responder with free-running auxiliary-channel conversion model
// Optional macro XADC_DRP_WRITE_EN enables writes to config registers CFG0..CFG2.
module xadc_drp_responder #(
    parameter int         CONV_CYCLES  = 100,
    parameter int         READ_LATENCY = 4,
    parameter logic [4:0] CHANNEL      = 5'h16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sample_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic        drdy_out,
    output logic [15:0] do_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        busy_out,
    output logic        proto_err_out
);

    localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
    localparam logic [3:0]  LAT_LAST  = 4'(READ_LATENCY - 1);
    localparam logic [15:0] CFG0_RST  = 16'h0016;
    localparam logic [15:0] CFG1_RST  = 16'h2000;
    localparam logic [15:0] CFG2_RST  = 16'h0400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] conv_cnt;
    logic [15:0] result;
    logic [3:0]  lat_cnt;
    logic        req_we;
    logic [6:0]  req_addr;
    logic [15:0] req_wdata;
    logic [15:0] req_rdata;
    logic [15:0] cfg0, cfg1, cfg2;
    logic [15:0] rd_mux;
    logic        accept;
    logic        finish;
    logic        fin_we;
    logic [6:0]  fin_addr;
    logic [15:0] fin_wdata;
    logic [15:0] fin_rdata;

    // Only S_WAIT counts as busy; a request landing in S_DONE starts the next transaction.
    assign accept = den_in && (state != S_WAIT);

    always_comb begin
        rd_mux = 16'h0000;
        if (daddr_in == {2'b00, CHANNEL}) begin
            rd_mux = result;
        end else begin
            case (daddr_in)
                7'h40:   rd_mux = cfg0;
                7'h41:   rd_mux = cfg1;
                7'h42:   rd_mux = cfg2;
                default: rd_mux = 16'h0000;
            endcase
        end
    end

    // With a latency of one the accepting edge is also the completing edge, so bypass the capture regs.
    always_comb begin
        finish    = (state == S_WAIT) && (lat_cnt == LAT_LAST);
        fin_we    = req_we;
        fin_addr  = req_addr;
        fin_wdata = req_wdata;
        fin_rdata = req_rdata;
        if (READ_LATENCY == 1) begin
            finish    = accept;
            fin_we    = dwe_in;
            fin_addr  = daddr_in;
            fin_wdata = di_in;
            fin_rdata = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_cnt    <= 16'd0;
            eoc_out     <= 1'b0;
            result      <= 16'h0000;
            channel_out <= 5'd0;
        end else begin
            eoc_out <= 1'b0;
            if (conv_cnt == CONV_LAST) begin
                conv_cnt    <= 16'd0;
                eoc_out     <= 1'b1;
                result      <= {sample_in, 4'b0000};
                channel_out <= CHANNEL;
            end else begin
                conv_cnt <= conv_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            lat_cnt       <= 4'd0;
            req_we        <= 1'b0;
            req_addr      <= 7'd0;
            req_wdata     <= 16'h0000;
            req_rdata     <= 16'h0000;
            drdy_out      <= 1'b0;
            do_out        <= 16'h0000;
            busy_out      <= 1'b0;
            proto_err_out <= 1'b0;
        end else begin
            drdy_out <= 1'b0;
            do_out   <= 16'h0000;
            if (den_in && (state == S_WAIT)) begin
                proto_err_out <= 1'b1;
            end
            if (finish) begin
                state    <= S_DONE;
                busy_out <= 1'b0;
                drdy_out <= 1'b1;
                do_out   <= fin_we ? 16'h0000 : fin_rdata;
            end else if (accept) begin
                state     <= S_WAIT;
                busy_out  <= 1'b1;
                lat_cnt   <= 4'd1;
                req_we    <= dwe_in;
                req_addr  <= daddr_in;
                req_wdata <= di_in;
                req_rdata <= rd_mux;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + 4'd1;
            end else begin
                state    <= S_IDLE;
                busy_out <= 1'b0;
            end
        end
    end

`ifdef XADC_DRP_WRITE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg0 <= CFG0_RST;
            cfg1 <= CFG1_RST;
            cfg2 <= CFG2_RST;
        end else if (finish && fin_we) begin
            case (fin_addr)
                7'h40:   cfg0 <= fin_wdata;
                7'h41:   cfg1 <= fin_wdata;
                7'h42:   cfg2 <= fin_wdata;
                default: ;
            endcase
        end
    end
`else
    logic unused_wr_path;
    assign unused_wr_path = ^{fin_addr, fin_wdata};
    assign cfg0 = CFG0_RST;
    assign cfg1 = CFG1_RST;
    assign cfg2 = CFG2_RST;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb/tb_xadc_drp_responder.sv - randomized model-checked bench for xadc_drp_responder
module tb_xadc_drp_responder;

    localparam int         CONV = 100;
    localparam int         RL   = 4;
    localparam logic [4:0] CH   = 5'h16;

    logic        clk;
    logic        rst_n;
    logic [11:0] sample_in;
    logic        den_in;
    logic        dwe_in;
    logic [6:0]  daddr_in;
    logic [15:0] di_in;
    logic        drdy_out;
    logic [15:0] do_out;
    logic        eoc_out;
    logic [4:0]  channel_out;
    logic        busy_out;
    logic        proto_err_out;

    int total = 0;
    int bad   = 0;

    xadc_drp_responder #(
        .CONV_CYCLES (CONV),
        .READ_LATENCY(RL),
        .CHANNEL     (CH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .den_in       (den_in),
        .dwe_in       (dwe_in),
        .daddr_in     (daddr_in),
        .di_in        (di_in),
        .drdy_out     (drdy_out),
        .do_out       (do_out),
        .eoc_out      (eoc_out),
        .channel_out  (channel_out),
        .busy_out     (busy_out),
        .proto_err_out(proto_err_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: edge count since reset release, one pending transaction, register file.
    int          m_n;
    bit          m_pend;
    int          m_done;
    bit          m_we;
    logic [6:0]  m_addr;
    logic [15:0] m_wd;
    logic [15:0] m_rd;
    logic [15:0] m_res;
    logic [15:0] m_cfg [3];
    bit          m_chv;
    bit          m_err;
    bit          e_drdy, e_eoc, e_busy;
    logic [15:0] e_do;

    function automatic logic [15:0] reg_val(input logic [6:0] a);
        if (a == {2'b00, CH}) return m_res;
        if (a >= 7'h40 && a <= 7'h42) return m_cfg[a - 7'h40];
        return 16'h0000;
    endfunction

    task automatic model_step();
        bit busy_prev;
        if (!rst_n) begin
            m_n = 0; m_pend = 0; m_done = 0; m_err = 0; m_chv = 0; m_res = 16'h0000;
            m_cfg[0] = 16'h0016; m_cfg[1] = 16'h2000; m_cfg[2] = 16'h0400;
            e_drdy = 0; e_eoc = 0; e_busy = 0; e_do = 16'h0000;
        end else begin
            m_n++;
            busy_prev = m_pend && (m_n - 1 < m_done);
            if (m_pend && (m_n - 1 >= m_done)) m_pend = 0;
            e_drdy = 0;
            e_do   = 16'h0000;
            if (den_in) begin
                if (busy_prev) begin
                    m_err = 1;
                end else begin
                    m_pend = 1; m_done = m_n + RL - 1;
                    m_we = dwe_in; m_addr = daddr_in; m_wd = di_in;
                    m_rd = reg_val(daddr_in);
                end
            end
            if (m_pend && m_n == m_done) begin
                e_drdy = 1;
                e_do   = m_we ? 16'h0000 : m_rd;
`ifdef XADC_DRP_WRITE_EN
                if (m_we && m_addr >= 7'h40 && m_addr <= 7'h42) m_cfg[m_addr - 7'h40] = m_wd;
`endif
            end
            e_eoc = (m_n % CONV) == 0;
            if (e_eoc) begin
                m_res = {sample_in, 4'h0};
                m_chv = 1;
            end
            e_busy = m_pend && (m_n < m_done);
        end
    endtask

    initial begin
        logic [24:0] act, expv;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            act  = {drdy_out, do_out, eoc_out, channel_out, busy_out, proto_err_out};
            expv = {e_drdy, e_do, e_eoc, (m_chv ? CH : 5'd0), e_busy, m_err};
            total++;
            if (act !== expv) begin
                bad++;
                $display("FAIL cycle_check n=%0d actual=%h required=%h", m_n, act, expv);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic drp(input logic [6:0] a, input bit we, input logic [15:0] d,
                       output logic [15:0] rd, output int lat, output logic [31:0] bmask);
        @(negedge clk);
        den_in = 1'b1; dwe_in = we; daddr_in = a; di_in = d;
        rd = 16'h0000; lat = -1; bmask = '0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            den_in = 1'b0;
            bmask[i] = busy_out;
            if (drdy_out) begin
                lat = i;
                rd  = do_out;
            end
        end
    endtask

    task automatic two_den(input int off, output int n);
        n = 0;
        @(negedge clk);
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h40;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (drdy_out) n++;
            den_in = (i == off);
        end
    endtask

    task automatic wait_eoc(output int at);
        at = -1;
        for (int i = 0; i < 300 && at < 0; i++) begin
            @(negedge clk);
            if (eoc_out) at = m_n;
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [31:0] bm;
        logic [6:0]  addrs [5];
        int          lat, at, n, hold;
        addrs[0] = 7'h16; addrs[1] = 7'h40; addrs[2] = 7'h41; addrs[3] = 7'h42; addrs[4] = 7'h7F;
        rst_n = 1'b0; sample_in = 12'hABC; den_in = 1'b0; dwe_in = 1'b0; daddr_in = 7'd0; di_in = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_drdy", {31'd0, drdy_out}, 32'd0);
        chk("reset_chan", {27'd0, channel_out}, 32'd0);
        chk("reset_busy", {31'd0, busy_out}, 32'd0);
        rst_n = 1'b1;

        drp(7'h16, 1'b0, 16'h0, rd, lat, bm);
        chk("read_latency", lat, 32'd4);
        chk("busy_window", bm, 32'h0000_000E);
        chk("result_before_eoc", {16'd0, rd}, 32'h0000);

        wait_eoc(at);
        chk("first_eoc_cycle", at, 32'd100);
        chk("channel_after_eoc", {27'd0, channel_out}, {27'd0, CH});
        drp(7'h16, 1'b0, 16'h0, rd, lat, bm);
        chk("result_abc0", {16'd0, rd}, 32'hABC0);
        drp(7'h7F, 1'b0, 16'h0, rd, lat, bm);
        chk("unmapped_read", {16'd0, rd}, 32'h0000);
        drp(7'h40, 1'b0, 16'h0, rd, lat, bm);
        chk("cfg0_reset", {16'd0, rd}, 32'h0016);
        drp(7'h42, 1'b0, 16'h0, rd, lat, bm);
        chk("cfg2_reset", {16'd0, rd}, 32'h0400);
        drp(7'h41, 1'b1, 16'h1234, rd, lat, bm);
        chk("write_do_zero", {16'd0, rd}, 32'h0000);
        chk("write_latency", lat, 32'd4);
        drp(7'h41, 1'b0, 16'h0, rd, lat, bm);
`ifdef XADC_DRP_WRITE_EN
        chk("cfg1_readback", {16'd0, rd}, 32'h1234);
`else
        chk("cfg1_readback", {16'd0, rd}, 32'h2000);
`endif
        two_den(4, n);
        chk("back_to_back_drdy", n, 32'd2);
        chk("back_to_back_noerr", {31'd0, proto_err_out}, 32'd0);

        for (int g = 0; g < 400 && m_n != 198; g++) @(negedge clk);
        sample_in = 12'h555;
        drp(7'h16, 1'b0, 16'h0, rd, lat, bm);
        chk("read_on_eoc_edge_old", {16'd0, rd}, 32'hABC0);
        drp(7'h16, 1'b0, 16'h0, rd, lat, bm);
        chk("read_new_result", {16'd0, rd}, 32'h5550);

        two_den(2, n);
        chk("overlap_one_drdy", n, 32'd1);
        chk("overlap_err", {31'd0, proto_err_out}, 32'd1);
        drp(7'h40, 1'b0, 16'h0, rd, lat, bm);
        chk("err_sticky", {31'd0, proto_err_out}, 32'd1);

        @(negedge clk);
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h16;
        @(negedge clk);
        den_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_out}, 32'd0);
        chk("abort_err_clear", {31'd0, proto_err_out}, 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (drdy_out) n++;
            if (i == 2) rst_n = 1'b1;
        end
        chk("abort_no_drdy", n, 32'd0);
        drp(7'h16, 1'b0, 16'h0, rd, lat, bm);
        chk("post_reset_latency", lat, 32'd4);
        chk("post_reset_result", {16'd0, rd}, 32'h0000);
        wait_eoc(at);
        chk("post_reset_eoc", at, 32'd100);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sample_in = 12'($urandom);
            den_in    = ($urandom_range(0, 3) == 0);
            dwe_in    = 1'($urandom);
            n         = $urandom_range(0, 5);
            daddr_in  = (n == 5) ? 7'($urandom) : addrs[n];
            di_in     = 16'($urandom);
            if (hold > 0) begin
                hold--;
                if (hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                hold  = $urandom_range(1, 3);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; den_in = 1'b0;
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
